// File: rtl/rr_sched_3_2_8_pkg.sv
// Shared types and constants for the 8-way round-robin scheduler.
// No logic; imported by the scheduler top and its decoder.
// Holds the FSM state encoding and requester sizing.
package rr_sched_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] RESET_PTR = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_sched_3_2_8_decoder.sv
// 3-to-8 binary-to-one-hot decoder.
// Purely combinational, zero latency.
// No flow control; output follows input.
module decoder_3_2_8 (
  input  logic [2:0] i,
  output logic [7:0] o
);

  // One bit set at the position named by the binary input.
  always_comb begin
    o = 8'b0000_0001 << i;
  end

endmodule

// File: rtl/rr_sched_3_2_8.sv
// Round-robin arbiter: grants one of 8 requesters, holds until done/withdraw/limit.
// Grant appears 1 cycle after a request is sampled; 1 idle cycle between grants.
// Grant held while req bit stays high; forced release after MAX_HOLD cycles.
module rr_sched_3_2_8
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16,  // legal 2..255
  parameter int CNT_W    = 8    // 2**CNT_W must exceed MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_oh,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] last_ptr;
  logic [IDX_W-1:0] winner;
  logic [N_REQ-1:0] oh_raw;
  logic             release_now;

  // First set request strictly after ptr, wrapping; ptr itself is checked last,
  // so the most recently served requester has the lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && r[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  // Winner of the next arbitration from the current request vector.
  always_comb begin
    winner = rr_pick(req, last_ptr);
  end

  // Voluntary release: grantee signals done or drops its request.
  always_comb begin
    release_now = done || !req[gnt_idx];
  end

  // Grant FSM with registered outputs and saturating hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_vld  <= 1'b0;
      gnt_idx  <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= RESET_PTR;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            gnt_vld  <= 1'b1;
            gnt_idx  <= winner;
            last_ptr <= winner;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            // Voluntary release wins over the limit: no timeout pulse.
            state    <= IDLE;
            gnt_vld  <= 1'b0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LIM) begin
            state    <= IDLE;
            gnt_vld  <= 1'b0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  decoder_3_2_8 u_dec (
    .i(gnt_idx),
    .o(oh_raw)
  );

  // One-hot derives only from registered state, never from req.
  assign gnt_oh = oh_raw & {N_REQ{gnt_vld}};
  assign busy   = gnt_vld;

endmodule

// File: tb/tb_rr_sched_3_2_8.sv
// Directed bench for the round-robin scheduler with hand-computed expectations.
module tb_rr_sched_3_2_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_oh;
  logic       timeout;
  logic       busy;

  int tests = 0;
  int fails = 0;

  rr_sched_3_2_8 #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx),
    .gnt_oh (gnt_oh),
    .timeout(timeout),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    chk({tag, "_vld"}, 32'(gnt_vld), 32'd1);
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, "_oh"},  32'(gnt_oh),  32'(oh));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic chk_idle(input string tag, input logic exp_to);
    chk({tag, "_vld"}, 32'(gnt_vld), 32'd0);
    chk({tag, "_idx"}, 32'(gnt_idx), 32'd0);
    chk({tag, "_oh"},  32'(gnt_oh),  32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_to"},  32'(timeout), 32'(exp_to));
  endtask

  initial begin
    logic [2:0] rot [8];
    rot = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    // Reset
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick(); tick();
    chk_idle("reset", 1'b0);

    // First grant after reset: last_ptr=7 so requester 0 beats 7
    rst = 1'b0; req = 8'b1000_0001;
    tick();
    chk_grant("first", 3'd0);

    // Rotation with all requesting
    req = 8'hFF; done = 1'b1;
    tick();
    chk_idle("rot_gap0", 1'b0);
    for (int k = 0; k < 8; k++) begin
      done = 1'b0;
      tick();
      chk_grant($sformatf("rot%0d", k), rot[k]);
      done = 1'b1;
      tick();
      chk_idle($sformatf("rot_gap%0d", k + 1), 1'b0);
    end

    // done while idle has no effect
    req = 8'h00; done = 1'b1;
    tick();
    chk_idle("idle_done", 1'b0);

    // Skip and wrap: grant 5, then 0 (past 6,7), then 3
    req = 8'h20; done = 1'b0;
    tick();
    chk_grant("skip5", 3'd5);
    req = 8'b0000_1001; done = 1'b1;
    tick();
    chk_idle("skip_gap1", 1'b0);
    done = 1'b0;
    tick();
    chk_grant("wrap0", 3'd0);
    done = 1'b1;
    tick();
    chk_idle("skip_gap2", 1'b0);
    done = 1'b0;
    tick();
    chk_grant("next3", 3'd3);
    done = 1'b1;
    tick();
    chk_idle("skip_gap3", 1'b0);

    // Timeout: 16 cycles of grant, timeout pulse, then re-grant
    req = 8'h04; done = 1'b0;
    tick();
    chk_grant("to_c1", 3'd2);
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk($sformatf("to_hold%0d_vld", c), 32'(gnt_vld), 32'd1);
      chk($sformatf("to_hold%0d_to", c), 32'(timeout), 32'd0);
    end
    tick();
    chk_idle("to_pulse", 1'b1);
    tick();
    chk_grant("to_regrant", 3'd2);
    chk("to_cleared", 32'(timeout), 32'd0);

    // Withdraw on the limit edge: release without timeout
    for (int c = 2; c <= 16; c++) begin
      tick();
    end
    chk("wd_pre_vld", 32'(gnt_vld), 32'd1);
    req = 8'h00;
    tick();
    chk_idle("wd_coll", 1'b0);
    tick();
    chk_idle("wd_after", 1'b0);

    // done on the limit edge: release without timeout
    req = 8'h04;
    tick();
    chk_grant("dn_grant", 3'd2);
    for (int c = 2; c <= 16; c++) begin
      tick();
    end
    chk("dn_pre_vld", 32'(gnt_vld), 32'd1);
    done = 1'b1;
    tick();
    chk_idle("dn_coll", 1'b0);
    done = 1'b0; req = 8'h00;
    tick();
    chk_idle("dn_after", 1'b0);

    // Reset mid-grant, then last_ptr back to 7
    req = 8'h40;
    tick();
    chk_grant("mid6", 3'd6);
    rst = 1'b1;
    tick();
    chk_idle("mid_rst", 1'b0);
    rst = 1'b0; req = 8'hC0;
    tick();
    chk_grant("post_rst", 3'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_sched_3_2_8.md
Name: rr_sched_3_2_8

Overview:
- Round-robin arbiter and scheduler that shares one 8-way resource among 8 requesters.
- Produces a 3-bit grant index and its one-hot form. The one-hot form comes from the team's 3-to-8 decoder, instantiated inside the block.
- Supports grant hold until release, a hold-time limit, and fair rotation of priority.
- Sits in front of any 8-slot datapath that is selected through the decoder.

Parameters:
MAX_HOLD, 16, maximum cycles one grant may be held before forced release; legal range 2..255.
CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk  input  1  rising-edge clock, the block's only clock.
rst  input  1  synchronous, active-high reset.
req  input  8  request vector; bit k is requester k. Level-sensitive.
done  input  1  release pulse from the current grantee; ignored when no grant is active.
gnt_vld  output  1  high while a grant is active.
gnt_idx  output  3  binary index of the granted requester; 0 when gnt_vld=0.
gnt_oh  output  8  one-hot grant, equal to decode(gnt_idx) gated by gnt_vld; all zero when idle.
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.
busy  output  1  equal to gnt_vld; provided for status logic.

Behaviour:
- Reset and clocking:
  - Interface: one clock, clk. Reset rst is synchronous and active-high.
  - While rst=1 at a clk edge: state=IDLE, gnt_vld=0, gnt_idx=0, gnt_oh=0, timeout=0, busy=0, hold_cnt=0, last_ptr=7. With last_ptr=7, requester 0 has top priority after reset.
  - rst asserted during GRANT aborts the grant. Outputs are zero the cycle after the rst edge. No timeout pulse is generated.
  - All outputs are registered. gnt_oh is decoded from the registered gnt_idx and gated by registered gnt_vld, so it has no combinational path from req.
- State IDLE:
  - At an edge with req != 0: pick the winner, the first set bit searching last_ptr+1, last_ptr+2, ... with wrap mod 8.
  - Load gnt_idx=winner, set last_ptr=winner, clear hold_cnt, go to GRANT. Grant latency is 1 cycle from req sampled to gnt_vld=1.
  - At an edge with req == 0: stay in IDLE.
- State GRANT: hold_cnt increments every cycle. Release happens at an edge when any of the following holds:
  - (a) done=1.
  - (b) req[gnt_idx]=0, i.e. the requester withdrew.
  - (c) hold_cnt == MAX_HOLD-1. This forces release and pulses timeout=1 for the next cycle.
  - On release: go to IDLE, and gnt_vld=0 the next cycle.
  - Priority when conditions coincide: done or withdraw take precedence over (c). If done=1 on the same edge as (c), no timeout is pulsed.
- Gap and fairness:
  - There is a mandatory one-cycle gap (gnt_vld=0) between consecutive grants, including re-grant to the same requester.
  - The requester just served has lowest priority at the next arbitration, because last_ptr points at it.
  - With all 8 requesting continuously, grants cycle 0,1,...,7,0.
- Requests and done outside GRANT:
  - Requests changing while in GRANT do not affect the current grant, except withdrawal of the granted bit.
  - done while in IDLE has no effect.
- Counter: hold_cnt saturates at MAX_HOLD-1 and never wraps. Its width is CNT_W.

Decomposition:
- Shared package rr_sched_pkg holds:
  - state enum: IDLE=1'b0, GRANT=1'b1.
  - constants N_REQ=8, IDX_W=3, RESET_PTR=3'd7.
- One sub-module: the existing decoder_3_2_8 (ports i[2:0], o[7:0]), instantiated to produce the ungated one-hot from gnt_idx.
- The priority search is a combinational function inside this block. It is not a separate module.

Test Plan:
- Reset / first grant: rst=1 for 2 cycles, then req=8'b1000_0001 -> gnt_vld=1, gnt_idx=0, gnt_oh=8'h01 one cycle after the first post-reset edge.
- Rotation: req=8'hFF held, done pulsed one cycle after each grant -> gnt_idx sequence 0,1,2,...,7,0. Each grant is separated by exactly 1 idle cycle, and gnt_oh matches 1<<gnt_idx.
- Skip and wrap: after a grant to 5, req=8'b0000_1001 -> next grant is idx 0 (wrap past 6,7), then idx 3.
- Timeout: MAX_HOLD=16, req=8'h04 held, done=0 -> gnt_idx=2 for exactly 16 cycles. Then timeout=1 for 1 cycle with gnt_vld=0, and idx 2 is re-granted the cycle after.
- Withdraw vs timeout collision: req[2] drops on the same edge hold_cnt reaches 15 -> release with timeout=0. done=1 coinciding with the limit also gives timeout=0.
- Reset mid-grant: rst=1 while gnt_idx=6 -> next cycle all outputs 0. After rst deasserts with req=8'hC0, the grant goes to idx 6 because last_ptr was reset to 7 and the search starts at 0.
